// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Returns one 32-bit result every 35 cycles; divide-by-zero and signed overflow finish in 2.

module adder32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        c_in_i,
   output logic [31:0] sum_o,
   output logic        c_out_o
);
   // With c_in set, b is inverted, so the unit computes a - b (c_out = no borrow).
   logic [31:0] b_eff;
   assign b_eff = c_in_i ? ~b_i : b_i;
   assign {c_out_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, c_in_i};
endmodule

// state | meaning
// IDLE  | ready; accepts a request, resolves div-by-zero / overflow directly
// CALC  | 32 restoring iterations, one quotient bit per cycle
// FIX   | apply result sign, register o_result
// DONE  | o_valid pulse
module div_unit (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_rs1,
   input  logic [31:0] i_rs2,
   input  logic        i_flush,
   output logic        o_busy,
   output logic        o_valid,
   output logic [31:0] o_result
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] r_q, r_d;
   logic [31:0] q_q, q_d;
   logic [31:0] dvs_q, dvs_d;
   logic [1:0]  op_q, op_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic [31:0] result_q, result_d;

   logic        sgn_in;
   logic [31:0] mag1, mag2;
   logic [31:0] shifted, trial;
   logic        trial_cout, success;
   logic [31:0] fix_sel, fix_neg;
   logic        fix_cout, fix_do_neg;

   assign sgn_in = ~i_op[0];
   assign mag1   = (sgn_in & i_rs1[31]) ? (32'd0 - i_rs1) : i_rs1;
   assign mag2   = (sgn_in & i_rs2[31]) ? (32'd0 - i_rs2) : i_rs2;

   assign shifted = {r_q[30:0], q_q[31]};
   adder32 u_trial (
      .a_i    (shifted),
      .b_i    (dvs_q),
      .c_in_i (1'b1),
      .sum_o  (trial),
      .c_out_o(trial_cout)
   );
   // r_q[31] is the implicit 33rd bit of the shifted value: the subtract always fits.
   assign success = r_q[31] | trial_cout;

   assign fix_sel    = op_q[1] ? r_q : q_q;
   assign fix_do_neg = op_q[1] ? negr_q : negq_q;
   adder32 u_neg (
      .a_i    (32'd0),
      .b_i    (fix_sel),
      .c_in_i (1'b1),
      .sum_o  (fix_neg),
      .c_out_o(fix_cout)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      q_d      = q_q;
      dvs_d    = dvs_q;
      op_d     = op_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               op_d   = i_op;
               negq_d = sgn_in & (i_rs1[31] ^ i_rs2[31]);
               negr_d = sgn_in & i_rs1[31];
               dvs_d  = mag2;
               if (i_rs2 == 32'd0) begin
                  result_d = i_op[1] ? i_rs1 : 32'hFFFF_FFFF;
                  state_d  = ST_DONE;
               end else if (sgn_in && i_rs1 == 32'h8000_0000 && i_rs2 == 32'hFFFF_FFFF) begin
                  result_d = i_op[1] ? 32'd0 : 32'h8000_0000;
                  state_d  = ST_DONE;
               end else begin
                  r_d     = 32'd0;
                  q_d     = mag1;
                  cnt_d   = 5'd0;
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            r_d   = success ? trial : shifted;
            q_d   = {q_q[30:0], success};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = ST_FIX;
         end
         ST_FIX: begin
            // Negating zero yields zero either way; carry-out flags that case.
            result_d = (fix_do_neg & ~fix_cout) ? fix_neg : fix_sel;
            state_d  = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (i_flush) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         r_q      <= 32'd0;
         q_q      <= 32'd0;
         dvs_q    <= 32'd0;
         op_q     <= 2'd0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
         q_q      <= q_d;
         dvs_q    <= dvs_d;
         op_q     <= op_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
      end
   end

   assign o_ready  = (state_q == ST_IDLE);
   assign o_busy   = (state_q != ST_IDLE);
   assign o_valid  = (state_q == ST_DONE);
   assign o_result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, flush/reset, then random ops
// against an arithmetic reference model.

module tb_div_unit;
   logic        i_clk = 1'b0;
   logic        i_reset, i_valid, i_flush;
   logic [1:0]  i_op;
   logic [31:0] i_rs1, i_rs2;
   logic        o_ready, o_busy, o_valid;
   logic [31:0] o_result;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] last_exp;

   div_unit dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_op    (i_op),
      .i_rs1   (i_rs1),
      .i_rs2   (i_rs2),
      .i_flush (i_flush),
      .o_busy  (o_busy),
      .o_valid (o_valid),
      .o_result(o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: RV32M semantics from plain signed/unsigned arithmetic.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      logic is_signed, is_rem;
      is_signed = (op == 2'b00) || (op == 2'b10);
      is_rem    = op[1];
      lat = 34;
      if (b == 0) begin
         res = is_rem ? a : 32'hFFFF_FFFF;
         lat = 1;
      end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         res = is_rem ? 32'd0 : 32'h8000_0000;
         lat = 1;
      end else if (is_signed) begin
         res = is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      end else begin
         res = is_rem ? (a % b) : (a / b);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit poke_busy);
      logic [31:0] exp_r;
      int exp_lat;
      int k;
      model(op, a, b, exp_r, exp_lat);
      i_op = op; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      i_op = 2'($urandom); i_rs1 = $urandom; i_rs2 = $urandom;
      k = 1;
      while (!o_valid && k < 60) begin
         if (poke_busy && k == 5) begin
            i_valid = 1'b1; i_rs2 = 32'd1;
         end
         tick();
         i_valid = 1'b0;
         k++;
      end
      chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
      chk({tag, "_res"}, o_result, exp_r);
      tick();
      chk({tag, "_rdy"}, {31'd0, o_ready}, 32'd1);
      last_exp = exp_r;
   endtask

   initial begin
      int k;
      int vseen;
      logic [31:0] a, b;
      i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
      i_op = 2'd0; i_rs1 = 32'd0; i_rs2 = 32'd0;
      tick(); tick();
      chk("rst_result", o_result, 32'd0);
      chk("rst_ready",  {31'd0, o_ready}, 32'd1);
      chk("rst_busy",   {31'd0, o_busy},  32'd0);
      chk("rst_valid",  {31'd0, o_valid}, 32'd0);
      i_reset = 1'b0;
      tick();

      run_op(2'b01, 32'd100, 32'd7, "divu_100_7", 1'b0);
      run_op(2'b11, 32'd100, 32'd7, "remu_100_7", 1'b0);
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1'b0);
      run_op(2'b00, 32'd7, 32'hFFFF_FFFE, "div_7_m2", 1'b0);
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2", 1'b0);
      run_op(2'b00, 32'd5, 32'd0, "div_by0", 1'b0);
      run_op(2'b11, 32'd5, 32'd0, "remu_by0", 1'b0);
      run_op(2'b01, 32'd0, 32'd0, "divu_0_0", 1'b0);
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_ovfops", 1'b0);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "remu_ovfops", 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, "divu_bit33", 1'b0);
      run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, "remu_bit33", 1'b0);
      run_op(2'b01, 32'd1000, 32'd9, "divu_busy_poke", 1'b1);

      // Flush at T+10: no completion, ready at T+11, result held; new op accepted at T+11.
      i_op = 2'b01; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      vseen = 0;
      for (k = 1; k < 10; k++) begin
         if (o_valid) vseen++;
         tick();
      end
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("flush_ready",  {31'd0, o_ready}, 32'd1);
      chk("flush_result", o_result, last_exp);
      chk("flush_novalid", 32'(vseen), 32'd0);
      run_op(2'b01, 32'd9, 32'd3, "divu_after_flush", 1'b0);

      // Flush together with an IDLE request drops it.
      i_op = 2'b01; i_rs1 = 32'd5; i_rs2 = 32'd0; i_valid = 1'b1; i_flush = 1'b1;
      tick();
      i_valid = 1'b0; i_flush = 1'b0;
      chk("flush_req_drop_busy", {31'd0, o_busy}, 32'd0);
      tick();
      chk("flush_req_drop_valid", {31'd0, o_valid}, 32'd0);

      // Reset at T+20 of an active op.
      i_op = 2'b00; i_rs1 = 32'd12345; i_rs2 = 32'd7; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      for (k = 1; k < 20; k++) tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      chk("rst_mid_result", o_result, 32'd0);
      chk("rst_mid_busy",   {31'd0, o_busy},  32'd0);
      chk("rst_mid_valid",  {31'd0, o_valid}, 32'd0);

      // Reset together with a request: not accepted.
      i_op = 2'b11; i_rs1 = 32'd5; i_rs2 = 32'd0; i_valid = 1'b1; i_reset = 1'b1;
      tick();
      i_valid = 1'b0; i_reset = 1'b0;
      chk("rst_req_busy", {31'd0, o_busy}, 32'd0);
      tick();
      chk("rst_req_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_req_result", o_result, 32'd0);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            2: a = 32'($urandom_range(0, 50));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         run_op(2'($urandom), a, b, "rand", 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage beside the ALU: it is fed by the ID/EX register and produces one 32-bit result for the EX/MEM register. Each iteration's trial subtraction runs through an `adder32` instance in subtract mode (`c_in=1`). While the unit is busy, the pipeline hazard logic stalls on `o_ready`/`o_busy`.

## Interface
- No parameters. Width is fixed at 32 to match the `adder32` datapath.

Ports:
- `i_clk` — in, 1 — clock; all state changes on the rising edge.
- `i_reset` — in, 1 — synchronous, active-high reset.
- `i_valid` — in, 1 — operation request; accepted when `i_valid & o_ready`.
- `o_ready` — out, 1 — high only in IDLE.
- `i_op` — in, 2 — `00` DIV, `01` DIVU, `10` REM, `11` REMU.
- `i_rs1` — in, 32 — dividend.
- `i_rs2` — in, 32 — divisor.
- `i_flush` — in, 1 — abort the current operation (branch mispredict / trap).
- `o_busy` — out, 1 — high whenever state ≠ IDLE.
- `o_valid` — out, 1 — one-cycle pulse; `o_result` is valid in that cycle.
- `o_result` — out, 32 — quotient (DIV/DIVU) or remainder (REM/REMU); holds its value until the next completion.

## Operation

States:
- **IDLE**
  - On accept, latch `i_op`, the operand magnitudes, and the sign flags (signed ops only).
  - Divisor == 0 → DONE. Result is `0xFFFFFFFF` for DIV/DIVU, or `i_rs1` for REM/REMU.
  - Signed op with `i_rs1=0x80000000` and `i_rs2=0xFFFFFFFF` → DONE. Result is `0x80000000` for DIV, or `0` for REM.
  - Otherwise → CALC with counter = 0, R = 0, Q = |rs1|.
- **CALC** (32 cycles)
  - Form the shifted value S = {R[30:0], Q[31]}.
  - Compute the trial value T = S − |rs2| via `adder32` (`a=S`, `b=|rs2|`, `c_in=1`).
  - Success = R[31] | `c_out`. The 33rd bit is R[31]; the low 32 bits of T are correct in both cases.
  - On success: R ← T[31:0]. Otherwise: R ← S.
  - Q ← {Q[30:0], success}.
  - After count 31 → FIX.
- **FIX** (1 cycle)
  - Quotient is negated when the op is signed and sign(rs1) ≠ sign(rs2).
  - Remainder is negated when the op is signed and rs1 < 0.
  - Negation uses a second `adder32` (`a=0`, `b=x`, `c_in=1`).
  - The selected value is registered into `o_result`. Next state: DONE.
- **DONE** (1 cycle)
  - `o_valid=1`. Next state: IDLE.
  - On the special-case paths, `o_result` is loaded on the IDLE→DONE edge.

Rules:
- Operands and op are sampled only at accept; later changes on the inputs are ignored.
- `i_valid` while not in IDLE is ignored. There is no queueing.
- `i_flush`, from any state:
  - Next state is IDLE and no `o_valid` is issued for the aborted op.
  - `o_result` keeps its prior value.
  - A flush in the same cycle as an IDLE request drops that request.
  - A flush in the DONE cycle does not suppress that cycle's `o_valid`; the flushing pipeline discards it.
- `i_reset` mid-operation has the same effect as a flush, and additionally clears `o_result`.
- Priority: `i_reset` > `i_flush` > accept.
- All arithmetic is modulo 2^32. |x| for 0x80000000 is 0x80000000, which is correct as an unsigned magnitude.

## Timing
- Reset values: state IDLE, `o_valid=0`, `o_busy=0`, `o_ready=1`, `o_result=0x00000000`, counter 0.
- Normal path, with accept in cycle T:
  - CALC in T+1..T+32.
  - FIX in T+33.
  - DONE (`o_valid=1`) in T+34.
  - `o_ready=1` again in T+35, so back-to-back throughput is one op per 35 cycles.
- Special path (divide-by-zero / overflow): accept in T, DONE in T+1, IDLE in T+2.
- Flush asserted in cycle F: IDLE and `o_ready=1` in F+1.
- `o_ready`, `o_busy` and `o_valid` are decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
- DIVU 100/7 accepted at T → `o_valid` in T+34 with `o_result=14`. REMU with the same operands → `2`.
- DIV `0xFFFFFFF9`/`2` → `0xFFFFFFFD`. REM with the same operands → `0xFFFFFFFF`. DIV 7/`0xFFFFFFFE` → `0xFFFFFFFD`, and REM → `1`.
- Divide by zero:
  - DIV 5/0 → `0xFFFFFFFF` with `o_valid` in T+1.
  - REMU 5/0 → `5` in T+1.
  - DIVU 0/0 → `0xFFFFFFFF`.
- Signed overflow and the related unsigned/33rd-bit cases:
  - DIV `0x80000000`/`0xFFFFFFFF` → `0x80000000` in T+1; REM → `0`.
  - DIVU on the same operands → `0` in T+34; REMU → `0x80000000`.
  - DIVU `0xFFFFFFFF`/`0x80000001` → `1`; REMU → `0x7FFFFFFE`. This exercises the R[31] success path.
- Flush, request-ignore and accept timing:
  - Flush at T+10 → no `o_valid` through T+40, `o_ready=1` at T+11, `o_result` unchanged.
  - A new DIVU 9/3 accepted at T+11 → `3` at T+45.
  - `i_valid` pulsed while busy is ignored.
- Reset:
  - `i_reset` at T+20 of an active op → at T+21, `o_result=0`, `o_busy=0`, `o_valid=0`.
  - Reset asserted together with `i_valid` → request not accepted.
